// File: rtl/calc_ctx_arbiter.sv
// calc_ctx_arbiter: round-robin sharing of one calculator datapath
// between two requesters, each with a private saved accumulator.
module calc_ctx_arbiter #(
  parameter int unsigned DP_LAT = 1
) (
  input  logic        CLC,
  input  logic        RESETn,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_op,
  input  logic [15:0] a_operand,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_op,
  input  logic [15:0] b_operand,
  output logic        a_rsp_valid,
  output logic        b_rsp_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic [2:0]  dp_op,
  output logic [15:0] dp_operand,
  output logic        dp_en,
  output logic        dp_load,
  output logic [15:0] dp_load_val,
  input  logic [15:0] dp_acc,
  input  logic        dp_zero,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWITCH = 3'd1,
    EXEC   = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef struct packed {
    logic        req;
    logic [2:0]  op;
    logic [15:0] operand;
  } req_t;

  state_t      state;
  state_t      state_nx;
  req_t        req_r;
  logic        last;
  logic        grant;
  logic        take;
  logic [15:0] ctx [2];
  logic [2:0]  cnt;

  // B wins when alone, or on a tie when A was served last
  assign grant = b_valid & (~a_valid | ~last);
  assign take  = (state == IDLE) & RESETn & (a_valid | b_valid);
  assign busy  = (state != IDLE);

  always_ff @(posedge CLC or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    dp_op       = 3'd0;
    dp_operand  = 16'd0;
    dp_en       = 1'b0;
    dp_load     = 1'b0;
    dp_load_val = 16'd0;
    unique case (state)
      IDLE: begin
        a_ready = RESETn & ~grant;
        b_ready = RESETn & grant;
        if (take) begin
          state_nx = (grant != owner) ? SWITCH : EXEC;
        end
      end
      SWITCH: begin
        dp_load     = 1'b1;
        dp_load_val = ctx[req_r.req];
        state_nx    = EXEC;
      end
      EXEC: begin
        dp_en      = 1'b1;
        dp_op      = req_r.op;
        dp_operand = req_r.operand;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        a_rsp_valid = ~req_r.req;
        b_rsp_valid = req_r.req;
        state_nx    = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLC or negedge RESETn) begin
    if (!RESETn) begin
      req_r      <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      ctx[0]     <= 16'd0;
      ctx[1]     <= 16'd0;
      cnt        <= 3'd0;
      rsp_result <= 16'd0;
      rsp_zero   <= 1'b0;
    end else begin
      if (take) begin
        req_r.req     <= grant;
        req_r.op      <= grant ? b_op : a_op;
        req_r.operand <= grant ? b_operand : a_operand;
        last          <= grant;
      end
      if (state == SWITCH) begin
        ctx[owner] <= dp_acc;
        owner      <= req_r.req;
      end
      if (state == EXEC) begin
        cnt <= 3'(DP_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          rsp_result <= dp_acc;
          rsp_zero   <= dp_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_ctx_arbiter.sv
// Bench: two arbiters (DP_LAT 1 and 3) with datapath models,
// scoreboard of per-requester accumulators and response timing.
module tb_calc_ctx_arbiter;

  logic CLC = 1'b0;
  logic RESETn = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0]  a_op = 3'd0, b_op = 3'd0;
  logic [15:0] a_operand = 16'd0, b_operand = 16'd0;

  logic        ar0, br0, arsp0, brsp0, rz0, en0, ld0, own0, busy0;
  logic [15:0] rr0, dopd0, dlv0;
  logic [2:0]  dop0;
  logic        ar1, br1, arsp1, brsp1, rz1, en1, ld1, own1, busy1;
  logic [15:0] rr1, dopd1, dlv1;
  logic [2:0]  dop1;

  logic [15:0] acc0, acc1, p1a, p1b;

  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_zero;
  logic        dp_en, dp_load, owner, busy;
  logic [15:0] rsp_result, dp_operand, dp_load_val;
  logic [2:0]  dp_op;

  typedef struct {
    logic        req;
    logic [15:0] res;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] macc [2];
  logic        mown = 1'b0, mlast = 1'b1;
  logic        w, wexp, sw, exp_sw = 1'b0;
  logic [2:0]  mop;
  logic [15:0] mopd, mres, exp_load = 16'd0;
  int          en_cnt = 0, stray = 0, dp_bad = 0;
  int          errs = 0, checks = 0;

  always #5 CLC = ~CLC;
  always @(posedge CLC) cyc <= cyc + 1;

  function automatic logic [15:0] alu(input logic [2:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5: return a << b[3:0];
      3'd6: return 16'($signed(a) >>> b[3:0]);
      default: return a ^ b;
    endcase
  endfunction

  calc_ctx_arbiter #(.DP_LAT(1)) dut0 (
    .CLC(CLC), .RESETn(RESETn),
    .a_valid(a_valid & ~sel), .a_ready(ar0),
    .a_op(a_op), .a_operand(a_operand),
    .b_valid(b_valid & ~sel), .b_ready(br0),
    .b_op(b_op), .b_operand(b_operand),
    .a_rsp_valid(arsp0), .b_rsp_valid(brsp0),
    .rsp_result(rr0), .rsp_zero(rz0),
    .dp_op(dop0), .dp_operand(dopd0), .dp_en(en0),
    .dp_load(ld0), .dp_load_val(dlv0),
    .dp_acc(acc0), .dp_zero(acc0 == 16'd0),
    .owner(own0), .busy(busy0)
  );

  calc_ctx_arbiter #(.DP_LAT(3)) dut1 (
    .CLC(CLC), .RESETn(RESETn),
    .a_valid(a_valid & sel), .a_ready(ar1),
    .a_op(a_op), .a_operand(a_operand),
    .b_valid(b_valid & sel), .b_ready(br1),
    .b_op(b_op), .b_operand(b_operand),
    .a_rsp_valid(arsp1), .b_rsp_valid(brsp1),
    .rsp_result(rr1), .rsp_zero(rz1),
    .dp_op(dop1), .dp_operand(dopd1), .dp_en(en1),
    .dp_load(ld1), .dp_load_val(dlv1),
    .dp_acc(p1b), .dp_zero(p1b == 16'd0),
    .owner(own1), .busy(busy1)
  );

  // datapath models: acc updates at the edge, visible DP_LAT cycles after dp_en
  always @(posedge CLC or negedge RESETn) begin
    if (!RESETn) begin
      acc0 <= 16'd0;
      acc1 <= 16'd0;
      p1a  <= 16'd0;
      p1b  <= 16'd0;
    end else begin
      if (ld0) acc0 <= dlv0;
      else if (en0) acc0 <= alu(dop0, acc0, dopd0);
      if (ld1) acc1 <= dlv1;
      else if (en1) acc1 <= alu(dop1, acc1, dopd1);
      p1a <= acc1;
      p1b <= p1a;
    end
  end

  assign a_ready     = sel ? ar1 : ar0;
  assign b_ready     = sel ? br1 : br0;
  assign a_rsp_valid = sel ? arsp1 : arsp0;
  assign b_rsp_valid = sel ? brsp1 : brsp0;
  assign rsp_result  = sel ? rr1 : rr0;
  assign rsp_zero    = sel ? rz1 : rz0;
  assign dp_en       = sel ? en1 : en0;
  assign dp_load     = sel ? ld1 : ld0;
  assign dp_op       = sel ? dop1 : dop0;
  assign dp_operand  = sel ? dopd1 : dopd0;
  assign dp_load_val = sel ? dlv1 : dlv0;
  assign owner       = sel ? own1 : own0;
  assign busy        = sel ? busy1 : busy0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // acceptance monitor and reference model
  always @(negedge CLC) begin
    if (!RESETn) begin
      macc[0] = 16'd0;
      macc[1] = 16'd0;
      mown    = 1'b0;
      mlast   = 1'b1;
      en_cnt  = 0;
      q.delete();
    end else begin
      if ((a_valid & a_ready) | (b_valid & b_ready)) begin
        if (a_valid && b_valid) wexp = !mlast;
        else wexp = b_valid;
        w = b_valid & b_ready;
        chk("grant", int'(w), int'(wexp));
        chk("accept_while_inflight", q.size(), 0);
        mop  = w ? b_op : a_op;
        mopd = w ? b_operand : a_operand;
        sw   = (w != mown);
        mres = alu(mop, macc[w], mopd);
        exp_load = macc[w];
        exp_sw   = sw;
        e.req  = w;
        e.res  = mres;
        e.zero = (mres == 16'd0);
        e.cyc  = cyc + 2 + (sel ? 3 : 1) + int'(sw);
        q.push_back(e);
        macc[w] = mres;
        mown    = w;
        mlast   = w;
      end
      if (dp_load) begin
        chk("dp_load_val", dp_load_val, exp_load);
        if (!exp_sw) dp_bad++;
      end
      if (dp_en) en_cnt++;
      if (dp_en && dp_load) dp_bad++;
      if (!dp_en && (dp_op != 3'd0 || dp_operand != 16'd0)) dp_bad++;
      if (!dp_load && dp_load_val != 16'd0) dp_bad++;
    end
    if (sel ? (arsp0 | brsp0) : (arsp1 | brsp1)) stray++;
  end

  // response monitor
  always @(negedge CLC) begin
    if (!RESETn) begin
      if (a_rsp_valid | b_rsp_valid) stray++;
    end else if (a_rsp_valid | b_rsp_valid) begin
      chk("rsp_expected", int'(q.size() > 0), 1);
      chk("rsp_both", int'(a_rsp_valid & b_rsp_valid), 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_req", int'(b_rsp_valid), int'(e.req));
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", int'(rsp_zero), int'(e.zero));
        chk("rsp_cycle", cyc, e.cyc);
        chk("dp_en_count", en_cnt, 1);
      end
      en_cnt = 0;
    end
  end

  task automatic issue(input logic who, input logic [2:0] op,
                       input logic [15:0] opd);
    int n;
    n = 0;
    if (who) begin
      b_valid = 1'b1; b_op = op; b_operand = opd;
    end else begin
      a_valid = 1'b1; a_op = op; a_operand = opd;
    end
    forever begin
      @(negedge CLC);
      if (who ? b_ready : a_ready) break;
      n++;
      if (n > 100) begin
        fail_now("accept");
        break;
      end
    end
    @(posedge CLC);
    #1;
    if (who) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLC);
      n++;
    end while ((q.size() != 0 || busy) && n < 200);
    if (n >= 200) fail_now("idle");
    chk("owner", int'(owner), int'(mown));
    @(posedge CLC);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLC);
    #1;
    RESETn  = 1'b0;
    a_valid = 1'b1;
    #2;
    chk("reset_ready", int'(a_ready | b_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_ctl", int'({a_rsp_valid, b_rsp_valid, dp_en, dp_load}), 0);
    chk("reset_data", rsp_result | dp_operand | dp_load_val, 0);
    a_valid = 1'b0;
    repeat (2) @(posedge CLC);
    #1;
    RESETn = 1'b1;
  endtask

  task automatic rand_txn();
    int r;
    r = $urandom_range(0, 2);
    if (r == 2) begin
      fork
        issue(1'b0, 3'($urandom), 16'($urandom));
        issue(1'b1, 3'($urandom), 16'($urandom));
      join
    end else begin
      issue(r[0], 3'($urandom), 16'($urandom));
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    issue(1'b0, 3'd2, 16'h354a); wait_idle();
    issue(1'b1, 3'd2, 16'h1234); wait_idle();
    issue(1'b0, 3'd3, 16'h1234); wait_idle();
    issue(1'b0, 3'd1, 16'h1001); wait_idle();

    do_reset();
    fork
      issue(1'b0, 3'd2, 16'h0042);
      issue(1'b1, 3'd2, 16'h1234);
    join
    wait_idle();
    issue(1'b1, 3'd3, 16'h1234); wait_idle();
    issue(1'b0, 3'd7, 16'hffff);
    b_valid = 1'b1; b_op = 3'd2; b_operand = 16'h0bad;
    repeat (2) @(posedge CLC);
    #1;
    b_valid = 1'b0;
    wait_idle();
    repeat (20) rand_txn();

    do_reset();
    sel = 1'b1;
    issue(1'b0, 3'd2, 16'h0001); wait_idle();
    issue(1'b1, 3'd2, 16'h0007); wait_idle();
    issue(1'b0, 3'd2, 16'h0001); wait_idle();
    issue(1'b0, 3'd2, 16'h0002);
    @(posedge CLC);
    do_reset();
    issue(1'b0, 3'd2, 16'h0004); wait_idle();
    issue(1'b1, 3'd2, 16'h0005); wait_idle();
    repeat (20) rand_txn();

    repeat (4) @(negedge CLC);
    chk("stray_rsp", stray, 0);
    chk("dp_idle_values", dp_bad, 0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
